mem_seq_checker: RTL and testbench

MEM_SEQ_CHECKER -- requirements
Module: mem_seq_checker

---
 rtl/mem_seq_checker_if.sv | 34 +++
 rtl/mem_seq_checker.sv | 162 ++++++++++++++++
 tb/tb_mem_seq_checker.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_checker_if.sv
// ============================================================================
// Module   : mem_seq_checker_if
// Purpose  : Controller/player-side bundle for the memory sequence checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_seq_checker_if;
    logic       seq_wr;
    logic [3:0] seq_digit;
    logic       seq_clr;
    logic       start;
    logic       p_press;
    logic [3:0] p_num;
    logic       busy;
    logic       round_win;
    logic       round_fail;
    logic [4:0] points;
    logic [4:0] p_echo;
    logic [4:0] seq_len;
    logic [4:0] entry_idx;

    modport master (
        output seq_wr, seq_digit, seq_clr, start, p_press, p_num,
        input  busy, round_win, round_fail, points, p_echo, seq_len, entry_idx
    );

    modport slave (
        input  seq_wr, seq_digit, seq_clr, start, p_press, p_num,
        output busy, round_win, round_fail, points, p_echo, seq_len, entry_idx
    );
endinterface

`default_nettype wire

// File: rtl/mem_seq_checker.sv
// ============================================================================
// Module   : mem_seq_checker
// Purpose  : Stores a digit sequence and checks a player's timed re-entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_seq_checker #(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 250000000
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_seq_checker_if.slave  bus
);

    localparam int             c_IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             c_TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);
    localparam logic [4:0]     c_MAX_LEN = 5'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTER = 2'd1,
        S_WIN   = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;

    logic [3:0]          r_mem [MAX_LEN];
    logic [4:0]          r_seq_len;
    logic [4:0]          r_entry_idx;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [4:0]          r_points;
    logic [4:0]          r_p_echo;
    logic                r_busy;
    logic                r_round_win;
    logic                r_round_fail;

    logic                w_start_ok;
    logic                w_wr_ok;
    logic                w_match;
    logic                w_last;
    logic                w_timeout;

    assign w_start_ok = bus.start && (r_seq_len != 5'd0);
    assign w_wr_ok    = (r_state == S_IDLE) && !bus.seq_clr && !w_start_ok
                        && bus.seq_wr && (r_seq_len < c_MAX_LEN);
    assign w_match    = (bus.p_num == r_mem[r_entry_idx[c_IDX_W-1:0]]);
    assign w_last     = (r_entry_idx == (r_seq_len - 5'd1));
    assign w_timeout  = (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                // Clear outranks start in the same cycle
                if (!bus.seq_clr && w_start_ok) begin
                    w_state_nx = S_ENTER;
                end
            end
            S_ENTER: begin
                if (bus.p_press) begin
                    if (!w_match) begin
                        w_state_nx = S_FAIL;
                    end else if (w_last) begin
                        w_state_nx = S_WIN;
                    end
                end else if (w_timeout) begin
                    w_state_nx = S_FAIL;
                end
            end
            S_WIN:   w_state_nx = S_IDLE;
            S_FAIL:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Digit storage carries no reset; contents are unreachable while seq_len is zero
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_seq_len[c_IDX_W-1:0]] <= bus.seq_digit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq_len    <= 5'd0;
            r_entry_idx  <= 5'd0;
            r_to_cnt     <= '0;
            r_points     <= 5'd0;
            r_p_echo     <= 5'd0;
            r_busy       <= 1'b0;
            r_round_win  <= 1'b0;
            r_round_fail <= 1'b0;
        end else begin
            r_busy       <= (w_state_nx == S_ENTER);
            r_round_win  <= (w_state_nx == S_WIN);
            r_round_fail <= (w_state_nx == S_FAIL);

            case (r_state)
                S_IDLE: begin
                    if (bus.seq_clr) begin
                        r_seq_len <= 5'd0;
                    end else if (w_start_ok) begin
                        r_entry_idx <= 5'd0;
                        r_to_cnt    <= '0;
                    end else if (w_wr_ok) begin
                        r_seq_len <= r_seq_len + 5'd1;
                    end
                end
                S_ENTER: begin
                    if (bus.p_press) begin
                        r_p_echo <= {1'b0, bus.p_num};
                        r_to_cnt <= '0;
                        if (w_match && !w_last) begin
                            r_entry_idx <= r_entry_idx + 5'd1;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    r_entry_idx <= 5'd0;
                end
            endcase

            // Score and sequence update on the transition into a result state
            if (r_state == S_ENTER && w_state_nx == S_WIN) begin
                r_entry_idx <= 5'd0;
                if (r_points != 5'd31) begin
                    r_points <= r_points + 5'd1;
                end
            end else if (r_state == S_ENTER && w_state_nx == S_FAIL) begin
                r_entry_idx <= 5'd0;
                r_points    <= 5'd0;
                r_seq_len   <= 5'd0;
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.round_win  = r_round_win;
    assign bus.round_fail = r_round_fail;
    assign bus.points     = r_points;
    assign bus.p_echo     = r_p_echo;
    assign bus.seq_len    = r_seq_len;
    assign bus.entry_idx  = r_entry_idx;

endmodule

`default_nettype wire

// File: tb/tb_mem_seq_checker.sv
// ============================================================================
// Module   : tb_mem_seq_checker
// Purpose  : Directed self-checking bench for mem_seq_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_seq_checker;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_seq_checker_if bus ();

    mem_seq_checker #(
        .MAX_LEN     (4),
        .TIMEOUT_CYC (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] d);
        bus.seq_wr = 1'b1; bus.seq_digit = d;
        tick();
        bus.seq_wr = 1'b0;
    endtask

    task automatic clr();
        bus.seq_clr = 1'b1;
        tick();
        bus.seq_clr = 1'b0;
    endtask

    task automatic go();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic press(input logic [3:0] n);
        bus.p_press = 1'b1; bus.p_num = n;
        tick();
        bus.p_press = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.points !== 5'd0) begin failures++; $display("FAIL reset_points got=%0d exp=0", bus.points); end
        checks++; if (bus.seq_len !== 5'd0) begin failures++; $display("FAIL reset_seq_len got=%0d exp=0", bus.seq_len); end
        checks++; if (bus.entry_idx !== 5'd0) begin failures++; $display("FAIL reset_entry_idx got=%0d exp=0", bus.entry_idx); end
        checks++; if (bus.p_echo !== 5'd0) begin failures++; $display("FAIL reset_p_echo got=%0d exp=0", bus.p_echo); end
        checks++; if ({bus.round_win, bus.round_fail} !== 2'b00) begin failures++; $display("FAIL reset_round got=%b exp=00", {bus.round_win, bus.round_fail}); end
    endtask

    task automatic test_win();
        wr(4'd3); wr(4'd7); wr(4'd1);
        checks++; if (bus.seq_len !== 5'd3) begin failures++; $display("FAIL win_len_before got=%0d exp=3", bus.seq_len); end
        press(4'd9);
        checks++; if (bus.p_echo !== 5'd0) begin failures++; $display("FAIL idle_press_ignored p_echo got=%0d exp=0", bus.p_echo); end
        go();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL win_busy got=%0b exp=1", bus.busy); end
        press(4'd3);
        checks++; if (bus.entry_idx !== 5'd1) begin failures++; $display("FAIL win_idx1 got=%0d exp=1", bus.entry_idx); end
        wr(4'd8);
        checks++; if (bus.seq_len !== 5'd3) begin failures++; $display("FAIL enter_wr_ignored got=%0d exp=3", bus.seq_len); end
        press(4'd7);
        checks++; if (bus.entry_idx !== 5'd2) begin failures++; $display("FAIL win_idx2 got=%0d exp=2", bus.entry_idx); end
        checks++; if (bus.round_win !== 1'b0) begin failures++; $display("FAIL win_early got=%0b exp=0", bus.round_win); end
        press(4'd1);
        checks++; if ({bus.round_win, bus.round_fail} !== 2'b10) begin failures++; $display("FAIL win_pulse got=%b exp=10", {bus.round_win, bus.round_fail}); end
        checks++; if (bus.points !== 5'd1) begin failures++; $display("FAIL win_points got=%0d exp=1", bus.points); end
        checks++; if (bus.seq_len !== 5'd3) begin failures++; $display("FAIL win_len got=%0d exp=3", bus.seq_len); end
        checks++; if (bus.p_echo !== 5'd1) begin failures++; $display("FAIL win_p_echo got=%0d exp=1", bus.p_echo); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL win_busy_low got=%0b exp=0", bus.busy); end
        tick();
        checks++; if (bus.round_win !== 1'b0) begin failures++; $display("FAIL win_one_cycle got=%0b exp=0", bus.round_win); end
        checks++; if (bus.entry_idx !== 5'd0) begin failures++; $display("FAIL win_idx_back got=%0d exp=0", bus.entry_idx); end
    endtask

    task automatic test_fail();
        clr();
        checks++; if (bus.seq_len !== 5'd0) begin failures++; $display("FAIL clr_len got=%0d exp=0", bus.seq_len); end
        wr(4'd3); wr(4'd7);
        go();
        press(4'd3);
        press(4'd5);
        checks++; if ({bus.round_win, bus.round_fail} !== 2'b01) begin failures++; $display("FAIL fail_pulse got=%b exp=01", {bus.round_win, bus.round_fail}); end
        checks++; if (bus.points !== 5'd0) begin failures++; $display("FAIL fail_points got=%0d exp=0", bus.points); end
        checks++; if (bus.seq_len !== 5'd0) begin failures++; $display("FAIL fail_len got=%0d exp=0", bus.seq_len); end
        checks++; if (bus.p_echo !== 5'd5) begin failures++; $display("FAIL fail_p_echo got=%0d exp=5", bus.p_echo); end
        tick();
        checks++; if (bus.round_fail !== 1'b0) begin failures++; $display("FAIL fail_one_cycle got=%0b exp=0", bus.round_fail); end
    endtask

    task automatic test_timeout();
        wr(4'd4);
        go();
        for (int i = 0; i < 9; i++) tick();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL to_busy_9 got=%0b exp=1", bus.busy); end
        checks++; if (bus.round_fail !== 1'b0) begin failures++; $display("FAIL to_early got=%0b exp=0", bus.round_fail); end
        tick();
        checks++; if (bus.round_fail !== 1'b1) begin failures++; $display("FAIL to_fail got=%0b exp=1", bus.round_fail); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL to_busy_low got=%0b exp=0", bus.busy); end
        tick();
    endtask

    task automatic test_limits();
        go();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL start_empty got=%0b exp=0", bus.busy); end
        wr(4'd1); wr(4'd2); wr(4'd3); wr(4'd4); wr(4'd5);
        checks++; if (bus.seq_len !== 5'd4) begin failures++; $display("FAIL max_len got=%0d exp=4", bus.seq_len); end
        go();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        checks++; if (bus.round_win !== 1'b1) begin failures++; $display("FAIL max_win got=%0b exp=1", bus.round_win); end
        tick();
        clr();
        wr(4'd6); wr(4'd2);
        bus.seq_wr = 1'b1; bus.seq_digit = 4'd9; bus.start = 1'b1;
        tick();
        bus.seq_wr = 1'b0; bus.start = 1'b0;
        checks++; if (bus.seq_len !== 5'd2) begin failures++; $display("FAIL start_wr_drop got=%0d exp=2", bus.seq_len); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL start_wr_busy got=%0b exp=1", bus.busy); end
        press(4'd6); press(4'd2);
        checks++; if (bus.round_win !== 1'b1) begin failures++; $display("FAIL start_wr_win got=%0b exp=1", bus.round_win); end
        tick();
        bus.seq_clr = 1'b1; bus.start = 1'b1; bus.seq_wr = 1'b1;
        tick();
        bus.seq_clr = 1'b0; bus.start = 1'b0; bus.seq_wr = 1'b0;
        checks++; if ({bus.busy, bus.seq_len} !== 6'd0) begin failures++; $display("FAIL clr_priority busy=%0b len=%0d exp=0/0", bus.busy, bus.seq_len); end
    endtask

    task automatic test_saturate();
        int exp_pts;
        rst = 1'b1; tick(); rst = 1'b0;
        exp_pts = 0;
        wr(4'd6);
        for (int i = 0; i < 32; i++) begin
            go();
            press(4'd6);
            exp_pts = (exp_pts < 31) ? exp_pts + 1 : 31;
            checks++; if (bus.round_win !== 1'b1 || bus.points !== 5'(exp_pts)) begin
                failures++; $display("FAIL sat_round%0d win=%0b points=%0d exp win=1 points=%0d", i, bus.round_win, bus.points, exp_pts);
            end
            tick();
        end
        checks++; if (bus.points !== 5'd31) begin failures++; $display("FAIL sat_final got=%0d exp=31", bus.points); end
    endtask

    task automatic test_reset_mid();
        clr();
        wr(4'd1); wr(4'd2); wr(4'd3);
        go();
        press(4'd1); press(4'd2);
        checks++; if (bus.entry_idx !== 5'd2) begin failures++; $display("FAIL mid_idx got=%0d exp=2", bus.entry_idx); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bus.busy, bus.round_win, bus.round_fail, bus.points, bus.p_echo, bus.seq_len, bus.entry_idx} !== 23'd0) begin
            failures++; $display("FAIL mid_reset busy=%0b win=%0b fail=%0b pts=%0d echo=%0d len=%0d idx=%0d exp all 0",
                                 bus.busy, bus.round_win, bus.round_fail, bus.points, bus.p_echo, bus.seq_len, bus.entry_idx);
        end
        press(4'd3);
        checks++; if ({bus.busy, bus.round_win, bus.p_echo} !== 7'd0) begin failures++; $display("FAIL mid_idle busy=%0b win=%0b echo=%0d exp 0", bus.busy, bus.round_win, bus.p_echo); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        bus.seq_wr = 1'b0; bus.seq_digit = 4'd0; bus.seq_clr = 1'b0;
        bus.start = 1'b0; bus.p_press = 1'b0; bus.p_num = 4'd0;
        test_reset();
        test_win();
        test_fail();
        test_timeout();
        test_limits();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
